// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//
// Multi-ported register file with a per-register pending ("busy") scoreboard.
//   - NREGS registers of DATA_W bits; register 0 is hard-wired to zero and has
//     no storage, so only NREGS-1 words exist.
//   - NRD independent combinational read ports, each returning the data and
//     the pending flag of the register it selects.
//   - Two write ports; on a shared target, port 1 takes priority.
//   - One reserve port that marks a register as awaiting a producer. A write
//     clears the pending flag, but a reserve in the same cycle keeps it set
//     because the reservation names a newer producer.
//
// Optional build macro:
//   RF_BYPASS_EN - forward same-cycle write data (and the resulting pending
//                  state) to the read ports. When undefined, reads return the
//                  stored state only.
//
// Reset: nRST is asynchronous and active-low. It clears every register and
// pending bit, and it forces the read ports to zero for as long as it is held.
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic                  wen0,
    input  logic                  wen1,
    input  logic [AW-1:0]         wsel0,
    input  logic [AW-1:0]         wsel1,
    input  logic [DATA_W-1:0]     wdat0,
    input  logic [DATA_W-1:0]     wdat1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_sel,
    output logic [NREGS-1:0]      busy
);

    // Storage exists for registers 1..NREGS-1 only.
    logic [DATA_W-1:0] regs_r [1:NREGS-1];
    logic [NREGS-1:1]  busy_r;

    // Per-register one-hot decode of the write and reserve ports.
    logic [NREGS-1:1]  wr0_hit_s;
    logic [NREGS-1:1]  wr1_hit_s;
    logic [NREGS-1:1]  rsv_hit_s;

    // Read view that includes the constant-zero register 0.
    logic [DATA_W-1:0] rd_view_s [0:NREGS-1];

    // Decode write and reserve targets; register 0 has no decode entry, so
    // writes and reserves aimed at it fall through and are ignored.
    always_comb begin
        wr0_hit_s = '0;
        wr1_hit_s = '0;
        rsv_hit_s = '0;
        for (int i = 1; i < NREGS; i++) begin
            wr0_hit_s[i] = wen0   && (wsel0   == AW'(i));
            wr1_hit_s[i] = wen1   && (wsel1   == AW'(i));
            rsv_hit_s[i] = rsv_en && (rsv_sel == AW'(i));
        end
    end

    // Commit write data; port 1 overrides port 0 when both target one register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wr1_hit_s[i]) begin
                    regs_r[i] <= wdat1;
                end else if (wr0_hit_s[i]) begin
                    regs_r[i] <= wdat0;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Track pending producers: a reserve sets the bit and beats a same-cycle
    // write; a write on its own clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_hit_s[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (wr0_hit_s[i] || wr1_hit_s[i]) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    // Register 0 is never pending.
    assign busy = {busy_r, 1'b0};

    // Build the zero-extended read view so read ports can index it directly.
    assign rd_view_s[0] = '0;
    for (genvar i = 1; i < NREGS; i++) begin : g_view
        assign rd_view_s[i] = regs_r[i];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     rs_s;
        logic [DATA_W-1:0] stored_s;
        logic              stored_busy_s;
        logic [DATA_W-1:0] data_s;
        logic              pend_s;

        assign rs_s          = rsel[k*AW +: AW];
        assign stored_s      = rd_view_s[rs_s];
        assign stored_busy_s = busy[rs_s];

`ifdef RF_BYPASS_EN
        logic byp0_s;
        logic byp1_s;
        logic rsv_s;

        // Forward same-cycle writes to this port; a matching write hides the
        // pending flag unless a matching reserve re-arms it in the same cycle.
        always_comb begin
            byp1_s = wen1   && (wsel1   == rs_s) && (rs_s != {AW{1'b0}});
            byp0_s = wen0   && (wsel0   == rs_s) && (rs_s != {AW{1'b0}});
            rsv_s  = rsv_en && (rsv_sel == rs_s);
            data_s = '0;
            pend_s = 1'b0;
            if (!nRST) begin
                data_s = '0;
                pend_s = 1'b0;
            end else begin
                if (byp1_s) begin
                    data_s = wdat1;
                end else if (byp0_s) begin
                    data_s = wdat0;
                end else begin
                    data_s = stored_s;
                end
                if ((byp1_s || byp0_s) && !rsv_s) begin
                    pend_s = 1'b0;
                end else begin
                    pend_s = stored_busy_s;
                end
            end
        end
`else
        // Stored state only; reads are forced to zero while reset is held.
        always_comb begin
            data_s = '0;
            pend_s = 1'b0;
            if (!nRST) begin
                data_s = '0;
                pend_s = 1'b0;
            end else begin
                data_s = stored_s;
                pend_s = stored_busy_s;
            end
        end
`endif

        assign rdat[k*DATA_W +: DATA_W] = data_s;
        assign rbusy[k]                 = pend_s;
    end

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// Self-checking bench for param_register_file (default parameters).
// A driver applies one stimulus vector per cycle at the falling edge and
// pushes the response predicted by an array-based reference model into a
// queue; a monitor pops that queue and compares it against the DUT outputs.
// Honours RF_BYPASS_EN when the macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_param_register_file;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int AW     = 5;

    logic                  CLK;
    logic                  nRST;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DATA_W-1:0] rdat;
    logic [NRD-1:0]        rbusy;
    logic                  wen0, wen1;
    logic [AW-1:0]         wsel0, wsel1;
    logic [DATA_W-1:0]     wdat0, wdat1;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_sel;
    logic [NREGS-1:0]      busy;

    param_register_file #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD)) dut (
        .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .wen0(wen0), .wen1(wen1), .wsel0(wsel0), .wsel1(wsel1),
        .wdat0(wdat0), .wdat1(wdat1), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [NRD*DATA_W-1:0] rdat;
        logic [NRD-1:0]        rbusy;
        logic [NREGS-1:0]      busy;
        string                 tag;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] m_mem  [0:NREGS-1];
    bit                m_busy [0:NREGS-1];
    int                n_vec = 0;
    int                n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one vector at the falling edge, predict the response, then advance
    // the model to the state after the next rising edge.
    task automatic apply(input bit w0, input int a0, input logic [31:0] d0,
                         input bit w1, input int a1, input logic [31:0] d1,
                         input bit rv, input int ra,
                         input int r0, input int r1, input string tag);
        exp_t e;
        @(negedge CLK);
        wen0 = w0; wsel0 = AW'(a0); wdat0 = d0;
        wen1 = w1; wsel1 = AW'(a1); wdat1 = d1;
        rsv_en = rv; rsv_sel = AW'(ra);
        rsel = {AW'(r1), AW'(r0)};
        e.tag = tag;
        e.rdat = '0;
        e.rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            int a;
            logic [31:0] v;
            bit b;
            a = (k == 0) ? r0 : r1;
            if (!nRST || a == 0) begin
                v = '0;
                b = 1'b0;
            end else begin
                v = m_mem[a];
                b = m_busy[a];
`ifdef RF_BYPASS_EN
                if (w1 && a1 == a) v = d1;
                else if (w0 && a0 == a) v = d0;
                if (((w1 && a1 == a) || (w0 && a0 == a)) && !(rv && ra == a)) b = 1'b0;
`endif
            end
            e.rdat[k*DATA_W +: DATA_W] = v;
            e.rbusy[k] = b;
        end
        for (int i = 0; i < NREGS; i++) begin
            e.busy[i] = nRST ? m_busy[i] : 1'b0;
        end
        exp_q.push_back(e);
        if (nRST) begin
            if (w0 && a0 != 0) begin m_mem[a0] = d0; m_busy[a0] = 1'b0; end
            if (w1 && a1 != 0) begin m_mem[a1] = d1; m_busy[a1] = 1'b0; end
            if (rv && ra != 0) m_busy[ra] = 1'b1;
        end
    endtask

    task automatic idle(input int r0, input int r1, input string tag);
        apply(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, r0, r1, tag);
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, " rdat"},  64'(rdat),  64'(e.rdat));
                check({e.tag, " rbusy"}, 64'(rbusy), 64'(e.rbusy));
                check({e.tag, " busy"},  64'(busy),  64'(e.busy));
            end
        end
    end

    initial begin
        nRST = 1'b0;
        wen0 = 1'b0; wen1 = 1'b0; wsel0 = '0; wsel1 = '0;
        wdat0 = '0; wdat1 = '0; rsv_en = 1'b0; rsv_sel = '0; rsel = '0;
        model_clear();

        // Activity while held in reset must be discarded.
        apply(1'b1, 4, 32'hCAFE0004, 1'b1, 6, 32'hCAFE0006, 1'b1, 8, 4, 6, "in_reset");
        idle(0, 0, "in_reset_idle");
        #3 nRST = 1'b1;

        // Everything reads zero after reset.
        for (int i = 0; i < NREGS; i++) idle(i, NREGS - 1 - i, "reset_read");

        // Basic write / read-back and register 0 immunity.
        apply(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 0, 5, 5, "wr5");
        idle(5, 0, "rd5");
        apply(1'b1, 0, 32'h00001234, 1'b0, 0, 32'h0, 1'b1, 0, 0, 0, "wr0");
        idle(0, 5, "rd0");

        // Port 1 wins on a shared target; distinct targets both commit.
        apply(1'b1, 7, 32'h11, 1'b1, 7, 32'h22, 1'b0, 0, 7, 0, "wr7_both");
        idle(7, 7, "rd7");
        apply(1'b1, 10, 32'hA0A0000A, 1'b1, 11, 32'hB0B0000B, 1'b0, 0, 10, 11, "wr10_11");
        idle(10, 11, "rd10_11");

        // Reserve / write interaction on register 9.
        apply(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9, 9, 0, "rsv9");
        idle(9, 0, "rd_rsv9");
        apply(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9, 9, 0, "rsv9_again");
        apply(1'b1, 9, 32'h99, 1'b0, 0, 32'h0, 1'b0, 0, 9, 0, "wr9");
        idle(9, 0, "rd_wr9");
        apply(1'b0, 0, 32'h0, 1'b1, 9, 32'h999, 1'b1, 9, 0, 9, "rsv_wr9");
        idle(9, 9, "rd_rsv_wr9");
        apply(1'b1, 12, 32'h12, 1'b0, 0, 32'h0, 1'b0, 0, 12, 9, "wr12_nobusy");
        idle(12, 9, "rd12");

        // Same-cycle read of a register being written.
        apply(1'b0, 0, 32'h0, 1'b1, 3, 32'hA5A5, 1'b0, 0, 0, 3, "wr3_rd3");
        idle(0, 3, "rd3");
        apply(1'b1, 3, 32'h0303, 1'b0, 0, 32'h0, 1'b1, 3, 3, 0, "wr3_rsv3_rd3");

        // Randomised traffic, addresses over the full range including 0.
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)), $urandom,
                  1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NREGS - 1)),
                  int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
                  "random");
        end

        // Asynchronous reset mid-sequence with state present.
        apply(1'b1, 20, 32'h20202020, 1'b0, 0, 32'h0, 1'b1, 21, 20, 21, "pre_areset");
        idle(20, 21, "pre_areset_rd");
        #3 nRST = 1'b0;
        #1;
        check("areset rdat",  64'(rdat),  64'(0));
        check("areset rbusy", 64'(rbusy), 64'(0));
        check("areset busy",  64'(busy),  64'(0));
        model_clear();
        apply(1'b1, 20, 32'h55, 1'b1, 22, 32'h66, 1'b1, 23, 20, 22, "areset_held");
        idle(20, 23, "areset_idle");
        #3 nRST = 1'b1;
        idle(20, 21, "post_areset");
        idle(22, 23, "post_areset2");

        for (int n = 0; n < 100; n++) begin
            apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "random_dense");
        end
        idle(0, 0, "final");

        repeat (3) @(negedge CLK);
        #4;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports (>=1).
REQ-004 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rsel  in  NRD*AW  read selects, port k at bits [k*AW +: AW].
REQ-007 SHALL have port rdat  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port rbusy  out  NRD  pending flag of register addressed by rsel port k.
REQ-009 SHALL have ports wen0/wen1  in  1 each  write enables, write ports 0 and 1.
REQ-010 SHALL have ports wsel0/wsel1  in  AW each  write addresses.
REQ-011 SHALL have ports wdat0/wdat1  in  DATA_W each  write data.
REQ-012 SHALL have port rsv_en  in  1  reserve request: mark a register as awaiting a producer.
REQ-013 SHALL have port rsv_sel  in  AW  register to reserve.
REQ-014 SHALL have port busy  out  NREGS  full pending-bit vector, bit i for register i.

Function
REQ-015 Register 0 SHALL read as zero on every port; writes and reserves to register 0 SHALL be ignored; busy[0] SHALL be constant 0.
REQ-016 Writes SHALL commit on the rising CLK edge in the cycle wen is high; stored value visible on rdat the following cycle.
REQ-017 Reads SHALL be combinational from stored state (zero-cycle latency), subject to REQ-027.
REQ-018 Simultaneous wen0 and wen1 to the same nonzero register SHALL commit wdat1 (port 1 wins); wdat0 discarded.
REQ-019 Simultaneous writes to different registers SHALL both commit in the same cycle.
REQ-020 rsv_en SHALL set busy[rsv_sel] on the next rising edge.
REQ-021 A committed write to register i SHALL clear busy[i] on the same edge.
REQ-022 rsv_en and a write to the same register in one cycle SHALL leave busy set (reservation wins, newer producer pending) while the write data still commits.
REQ-023 Reserving an already-busy register SHALL keep it busy; writing a non-busy register SHALL commit data and leave busy clear.
REQ-024 rbusy[k] SHALL equal busy[rsel port k] from stored state, combinational.
REQ-025 Unused register bits SHALL not exist: storage is exactly NREGS-1 words (register 0 not stored).

Reset
REQ-026 nRST low SHALL asynchronously clear all registers to 0 and all busy bits to 0; rdat and rbusy SHALL read 0 throughout reset; a write or reserve asserted during reset SHALL be discarded, and operation resumes on the first rising edge after nRST rises.

Configuration
REQ-027 Macro RF_BYPASS_EN SHALL, when defined, forward same-cycle write data to reads: rdat port k returns wdat1 if wen1 and wsel1==rsel k (nonzero), else wdat0 if wen0 and wsel0 matches, else stored value; rbusy port k SHALL read 0 when a matching write is present and no matching rsv_en exists in that cycle.
REQ-028 Without RF_BYPASS_EN, reads SHALL return stored values only; writes are visible the cycle after commit.

Verification
REQ-029 Reset then read all registers on all ports -> every rdat 0, busy all 0.
REQ-030 wen0=1 wsel0=5 wdat0=0xDEADBEEF; next cycle rsel0=5 -> rdat port0 0xDEADBEEF; write 0x1234 to reg 0 -> reg 0 still reads 0.
REQ-031 wen0 and wen1 both to reg 7, wdat0=0x11, wdat1=0x22 -> reg 7 reads 0x22 next cycle.
REQ-032 rsv_en reg 9 -> busy[9]=1 next cycle; then write reg 9 -> busy[9]=0; rsv_en and write reg 9 same cycle -> busy[9]=1, data committed.
REQ-033 With RF_BYPASS_EN: wen1 reg 3 wdat1=0xA5A5 and rsel1=3 same cycle -> rdat port1 0xA5A5 that cycle; without macro -> old value that cycle, 0xA5A5 next.
REQ-034 Assert nRST low mid-sequence with regs and busy bits set -> all cleared immediately without a clock edge.
